irig_frame_sync: RTL and testbench
==================================

Name: irig_frame_sync

Overview:
Frame controller that sits between the IRIG-B pulse-width classifier and the rest of the timing logic in the irig decoder.
- Consumes classified symbols (D0/D1/MARK) and rising-edge strobes.
- Acquires frame alignment from the double-marker (P0,Pr) pattern and sequences the 100-symbol frame index.
- Checks position markers, assembles BCD/SBS time fields, and schedules the PPS pulse on the Pr on-time edge.
- Drops lock on errors or symbol timeouts.

Parameters:
TIMEOUT_CYC, 120000, max clk_10mhz cycles between sym_valid strobes (12 ms) before loss of lock
PPS_CYC, 1, pps high width in clock cycles (1..2^20-1)

Ports:
clk_10mhz  in  1  system clock, 10 MHz
rst  in  1  asynchronous, active-low reset (asserted at 0)
sym_valid  in  1  one-cycle strobe: sym holds a newly classified symbol
sym  in  2  00=D0, 01=D1, 10=MARK, 11=malformed pulse
sym_rise  in  1  one-cycle strobe on each IRIG rising edge (bit start)
pps  out  1  on-time pulse, rising edge aligned to Pr edge
locked  out  1  a complete, error-free frame has been received and sync is held
ts_valid  out  1  one-cycle strobe: time fields updated
seconds  out  7  BCD {tens[2:0],units[3:0]}
minutes  out  7  BCD {tens[2:0],units[3:0]}
hours  out  6  BCD {tens[1:0],units[3:0]}
days  out  10  BCD {hundreds[1:0],tens[3:0],units[3:0]}
years  out  8  BCD {tens[3:0],units[3:0]}
frame_err  out  1  one-cycle strobe on any frame violation

Behaviour:
- Reset (rst=0, async): all outputs 0; state HUNT; idx=0; watchdog cleared; pps counter 0; arm=0.
- FSM states:
  - HUNT: MARK -> PMARK; other symbols are ignored.
  - PMARK: MARK -> FRAME with idx=1 (this MARK is Pr, idx 0); D0/D1 -> HUNT; 11 -> HUNT.
  - FRAME: each sym_valid is checked against idx.
- FRAME marker rules:
  - Marker indices {0,9,19,...,99} require MARK.
  - Other indices require D0/D1; D1=binary 1.
  - Any mismatch or sym=11 -> frame_err pulse, locked<=0, arm<=0, state HUNT. A MARK at a wrong index goes to PMARK instead, so resync is possible.
- Index advance: idx increments 0..99 and wraps 99->0.
- Field capture: bits are written into shadow registers by index. LSB-first within each digit.
  - seconds: 1-4 units, 6-8 tens.
  - minutes: 10-13 units, 15-17 tens.
  - hours: 20-23 units, 25-26 tens.
  - days: 30-33 units, 35-38 tens, 40-41 hundreds.
  - years: 50-53 units, 55-58 tens.
  - Other indices are ignored.
- Frame complete (idx 99 MARK accepted), next cycle:
  - shadows copy to outputs;
  - ts_valid=1 for one cycle;
  - locked<=1;
  - arm<=1;
  - shadows cleared.
- PPS scheduling:
  - While arm=1 and locked=1, the next sym_rise starts pps. pps stays high PPS_CYC cycles; arm<=0.
  - sym_rise with arm=0 has no effect.
  - Latency: pps rises 1 cycle after the sym_rise strobe.
- Simultaneous events: sym_rise and sym_valid in the same cycle are both processed. A pps already running completes its width even if lock drops.
- Watchdog:
  - Counter resets on every sym_valid.
  - Reaching TIMEOUT_CYC in any state except HUNT -> state HUNT, locked<=0, arm<=0, frame_err pulse.
  - In HUNT the counter saturates and no pulse is issued.
- Field outputs hold their last values after loss of lock; only ts_valid/locked indicate freshness.

Optional Feature:
IRIG_SBS_EN: defined adds output port sbs [16:0], straight-binary seconds-of-day.
- Bits 80-88 -> sbs[8:0]; bits 90-97 -> sbs[16:9].
- Captured and updated with the other fields at ts_valid; reset 0.

Undefined: port, shadow and capture logic are absent; indices 80-97 are only marker/format checked.

Decomposition:
- Package irig_pkg: symbol encodings (SYM_D0, SYM_D1, SYM_MARK, SYM_ERR), FSM state enum, marker index constant list, field index constants.
- One sub-module, irig_pps_gen: arm/trigger/width counter for pps. The frame FSM stays in irig_frame_sync.

Test Plan:
- Lock acquisition:
  - Stimulus: reset, then 4 garbage symbols (D0,MARK,D1,D0), MARK, then a full frame encoding 17:59:42, day 293, year 16 (SBS 64782), then MARK.
  - Response: ts_valid once; seconds=7'h42, minutes=7'h59, hours=6'h17, days=10'h293, years=8'h16, locked=1; sbs=17'd64782 with IRIG_SBS_EN; pps rises 1 cycle after the following sym_rise.
- Marker error: D1 at idx 29 -> frame_err pulse, locked=0, no ts_valid, no pps on the next rising edge.
- Symbol timeout: locked, then no sym_valid for 120000 cycles -> frame_err at cycle 120000, locked=0.
- Reset mid-frame: rst=0 at idx 45 -> all outputs 0 immediately; after release, requires a new MARK,MARK to resync.
- Back-to-back frames: two consecutive valid frames with seconds 42 then 43 -> ts_valid twice, ~1e7 cycles apart; seconds=7'h43; exactly two pps pulses, each PPS_CYC wide.

Source files
------------

// File: rtl/irig_pkg.sv
// Symbol encodings, FSM states and frame index tables for the IRIG-B frame synchronizer.
// IRIG_SBS_EN widens the capture word with the straight-binary seconds-of-day field.
package irig_pkg;

  localparam logic [1:0] SYM_D0   = 2'b00;
  localparam logic [1:0] SYM_D1   = 2'b01;
  localparam logic [1:0] SYM_MARK = 2'b10;
  localparam logic [1:0] SYM_ERR  = 2'b11;

  localparam logic [1:0] ST_HUNT  = 2'd0;
  localparam logic [1:0] ST_PMARK = 2'd1;
  localparam logic [1:0] ST_FRAME = 2'd2;

  localparam logic [6:0] IDX_LAST = 7'd99;

  // Capture word layout: one flat vector, fields packed LSB-first.
  localparam int SEC_LSB = 0;
  localparam int MIN_LSB = 7;
  localparam int HR_LSB  = 14;
  localparam int DAY_LSB = 20;
  localparam int YR_LSB  = 30;
  localparam int SBS_LSB = 38;
`ifdef IRIG_SBS_EN
  localparam int CAP_W = 55;
`else
  localparam int CAP_W = 38;
`endif

  typedef struct packed {
    logic       en;
    logic [5:0] pos;
  } cap_t;

  function automatic logic [99:0] marker_mask();
    logic [99:0] m;
    m    = '0;
    m[0] = 1'b1;
    for (int i = 9; i < 100; i += 10) m[i] = 1'b1;
    return m;
  endfunction

  localparam logic [99:0] MARKER_MASK = marker_mask();

  // Maps a frame index to its bit position in the capture word.
  function automatic cap_t cap_map(input logic [6:0] idx);
    cap_t c;
    c.en  = 1'b1;
    c.pos = '0;
    if      (idx inside {[7'd1:7'd4]})   c.pos = 6'(idx - 7'd1);
    else if (idx inside {[7'd6:7'd8]})   c.pos = 6'(idx - 7'd2);
    else if (idx inside {[7'd10:7'd13]}) c.pos = 6'(idx - 7'd3);
    else if (idx inside {[7'd15:7'd17]}) c.pos = 6'(idx - 7'd4);
    else if (idx inside {[7'd20:7'd23]}) c.pos = 6'(idx - 7'd6);
    else if (idx inside {[7'd25:7'd26]}) c.pos = 6'(idx - 7'd7);
    else if (idx inside {[7'd30:7'd33]}) c.pos = 6'(idx - 7'd10);
    else if (idx inside {[7'd35:7'd38]}) c.pos = 6'(idx - 7'd11);
    else if (idx inside {[7'd40:7'd41]}) c.pos = 6'(idx - 7'd12);
    else if (idx inside {[7'd50:7'd53]}) c.pos = 6'(idx - 7'd20);
    else if (idx inside {[7'd55:7'd58]}) c.pos = 6'(idx - 7'd21);
`ifdef IRIG_SBS_EN
    else if (idx inside {[7'd80:7'd88]}) c.pos = 6'(idx - 7'd42);
    else if (idx inside {[7'd90:7'd97]}) c.pos = 6'(idx - 7'd43);
`endif
    else c.en = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/irig_pps_gen.sv
// PPS generator: armed at frame completion, fires on the next rising edge while locked,
// and holds pps high for PPS_CYC cycles regardless of later lock loss.
module irig_pps_gen #(
  parameter int unsigned PPS_CYC = 1
) (
  input  logic clk_10mhz,
  input  logic rst,
  input  logic arm_set_i,
  input  logic arm_clr_i,
  input  logic locked_i,
  input  logic sym_rise_i,
  output logic pps_o
);

  localparam int CW = 20;

  logic          arm_q, arm_d;
  logic          pps_q, pps_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          trig;

  assign trig  = sym_rise_i && arm_q && locked_i;
  assign pps_o = pps_q;

  always_comb begin
    arm_d = arm_q;
    pps_d = pps_q;
    cnt_d = cnt_q;
    if (pps_q) begin
      if (cnt_q == '0) pps_d = 1'b0;
      else             cnt_d = cnt_q - CW'(1);
    end
    if (trig) begin
      pps_d = 1'b1;
      cnt_d = CW'(PPS_CYC - 1);
      arm_d = 1'b0;
    end
    if (arm_set_i) arm_d = 1'b1;
    if (arm_clr_i) arm_d = 1'b0;
  end

  always_ff @(posedge clk_10mhz or negedge rst) begin
    if (!rst) begin
      arm_q <= 1'b0;
      pps_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      arm_q <= arm_d;
      pps_q <= pps_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/irig_frame_sync.sv
// IRIG-B frame controller: acquires double-marker alignment, checks the 100-symbol frame,
// assembles BCD time fields and schedules pps. IRIG_SBS_EN adds the sbs output.
module irig_frame_sync
  import irig_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 120000,
  parameter int unsigned PPS_CYC     = 1
) (
  input  logic        clk_10mhz,
  input  logic        rst,
  input  logic        sym_valid,
  input  logic [1:0]  sym,
  input  logic        sym_rise,
  output logic        pps,
  output logic        locked,
  output logic        ts_valid,
  output logic [6:0]  seconds,
  output logic [6:0]  minutes,
  output logic [5:0]  hours,
  output logic [9:0]  days,
  output logic [7:0]  years,
`ifdef IRIG_SBS_EN
  output logic [16:0] sbs,
`endif
  output logic        frame_err
);

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_TO    = WD_W'(TIMEOUT_CYC);
  localparam logic [WD_W-1:0] WD_TO_M1 = WD_W'(TIMEOUT_CYC - 1);

  logic [1:0]       state_q, state_d;
  logic [6:0]       idx_q, idx_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [CAP_W-1:0] shadow_q, shadow_d;
  logic [CAP_W-1:0] fields_q, fields_d;
  logic             locked_q, locked_d;
  logic             ts_valid_q, ts_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             arm_set, arm_clr;
  logic             is_mark, bad_sym;
  cap_t             cap;

  assign is_mark = (sym == SYM_MARK);
  assign bad_sym = (sym == SYM_ERR) || (is_mark != MARKER_MASK[idx_q]);
  assign cap     = cap_map(idx_q);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    fields_d    = fields_q;
    locked_d    = locked_q;
    ts_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    arm_set     = 1'b0;
    arm_clr     = 1'b0;
    wd_d        = (wd_q == WD_TO) ? wd_q : wd_q + WD_W'(1);
    if (sym_valid) begin
      wd_d = '0;
      case (state_q)
        ST_HUNT:  if (is_mark) state_d = ST_PMARK;
        ST_PMARK: begin
          // Second consecutive MARK is Pr (index 0); next symbol is index 1.
          state_d = is_mark ? ST_FRAME : ST_HUNT;
          idx_d   = is_mark ? 7'd1 : 7'd0;
        end
        ST_FRAME: begin
          if (bad_sym) begin
            frame_err_d = 1'b1;
            locked_d    = 1'b0;
            arm_clr     = 1'b1;
            idx_d       = '0;
            state_d     = is_mark ? ST_PMARK : ST_HUNT;
          end else begin
            if (cap.en) shadow_d[cap.pos] = sym[0];
            if (idx_q == IDX_LAST) begin
              idx_d      = '0;
              fields_d   = shadow_d;
              shadow_d   = '0;
              ts_valid_d = 1'b1;
              locked_d   = 1'b1;
              arm_set    = 1'b1;
            end else begin
              idx_d = idx_q + 7'd1;
            end
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end else if (state_q != ST_HUNT && wd_q == WD_TO_M1) begin
      state_d     = ST_HUNT;
      idx_d       = '0;
      locked_d    = 1'b0;
      arm_clr     = 1'b1;
      frame_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_10mhz or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_HUNT;
      idx_q       <= '0;
      wd_q        <= '0;
      shadow_q    <= '0;
      fields_q    <= '0;
      locked_q    <= 1'b0;
      ts_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wd_q        <= wd_d;
      shadow_q    <= shadow_d;
      fields_q    <= fields_d;
      locked_q    <= locked_d;
      ts_valid_q  <= ts_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  irig_pps_gen #(.PPS_CYC(PPS_CYC)) u_pps (
    .clk_10mhz  (clk_10mhz),
    .rst        (rst),
    .arm_set_i  (arm_set),
    .arm_clr_i  (arm_clr),
    .locked_i   (locked_q),
    .sym_rise_i (sym_rise),
    .pps_o      (pps)
  );

  assign locked    = locked_q;
  assign ts_valid  = ts_valid_q;
  assign frame_err = frame_err_q;
  assign seconds   = fields_q[SEC_LSB +: 7];
  assign minutes   = fields_q[MIN_LSB +: 7];
  assign hours     = fields_q[HR_LSB  +: 6];
  assign days      = fields_q[DAY_LSB +: 10];
  assign years     = fields_q[YR_LSB  +: 8];
`ifdef IRIG_SBS_EN
  assign sbs       = fields_q[SBS_LSB +: 17];
`endif

endmodule

// File: tb/tb_irig_frame_sync.sv
// Scoreboard bench for irig_frame_sync: expected ts/frame_err/pps events are queued as
// symbols are driven and checked as the DUT emits them. Works with or without IRIG_SBS_EN.
module tb_irig_frame_sync;

  localparam int unsigned TO   = 100;
  localparam int unsigned PCYC = 3;
  localparam int PER = 20;
  localparam int R2V = 8;
  localparam logic [1:0] D0 = 2'b00, D1 = 2'b01, MK = 2'b10;

  typedef struct packed {
    logic [6:0]  s;
    logic [6:0]  m;
    logic [5:0]  h;
    logic [9:0]  d;
    logic [7:0]  y;
    logic [16:0] b;
  } ts_t;

  logic        clk = 1'b0, rst = 1'b0, sym_valid = 1'b0, sym_rise = 1'b0;
  logic [1:0]  sym = 2'b00;
  logic        pps, locked, ts_valid, frame_err;
  logic [6:0]  seconds, minutes;
  logic [5:0]  hours;
  logic [9:0]  days;
  logic [7:0]  years;
  logic [16:0] sbs_obs;

  irig_frame_sync #(.TIMEOUT_CYC(TO), .PPS_CYC(PCYC)) dut (
    .clk_10mhz (clk),
    .rst       (rst),
    .sym_valid (sym_valid),
    .sym       (sym),
    .sym_rise  (sym_rise),
    .pps       (pps),
    .locked    (locked),
    .ts_valid  (ts_valid),
    .seconds   (seconds),
    .minutes   (minutes),
    .hours     (hours),
    .days      (days),
    .years     (years),
`ifdef IRIG_SBS_EN
    .sbs       (sbs_obs),
`endif
    .frame_err (frame_err)
  );
`ifndef IRIG_SBS_EN
  assign sbs_obs = '0;
`endif

  always #50 clk = ~clk;

  ts_t exp_ts[$];
  int  exp_err[$];
  int  exp_pps[$];
  int  vecs = 0, errs = 0, cyc = 0, pps_cnt = 0, pps_w = 0, last_ts = -1, last_v = 0;
  bit  pps_prev = 1'b0, err_seen = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    ts_t got, e;
    if (ts_valid) begin
      chk("ts_pending", 64'(exp_ts.size() != 0), 64'd1);
      if (exp_ts.size() != 0) begin
        got = {seconds, minutes, hours, days, years, sbs_obs};
        e   = exp_ts.pop_front();
        chk("ts_fields", 64'(got), 64'(e));
        chk("ts_locked", 64'(locked), 64'd1);
      end
      last_ts = cyc;
    end
    if (frame_err) begin
      err_seen = 1'b1;
      chk("err_pending", 64'(exp_err.size() != 0), 64'd1);
      if (exp_err.size() != 0) chk("err_cycle", 64'(cyc), 64'(exp_err.pop_front()));
    end
    if (pps && !pps_prev) begin
      pps_cnt++;
      pps_w = 0;
      chk("pps_pending", 64'(exp_pps.size() != 0), 64'd1);
      if (exp_pps.size() != 0) chk("pps_rise_cycle", 64'(cyc), 64'(exp_pps.pop_front()));
    end
    if (pps) pps_w++;
    if (!pps && pps_prev) chk("pps_width", 64'(pps_w), 64'(PCYC));
    pps_prev = pps;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    monitor();
  endtask

  // One IRIG symbol slot: rising edge strobe, then the classified symbol R2V cycles later.
  task automatic send(input logic [1:0] s, input bit want_pps, input bit want_err);
    if (want_pps) exp_pps.push_back(cyc + 1);
    sym_rise = 1'b1;
    tick();
    sym_rise = 1'b0;
    repeat (R2V - 1) tick();
    if (want_err) exp_err.push_back(cyc + 1);
    sym = s;
    sym_valid = 1'b1;
    tick();
    sym_valid = 1'b0;
    last_v = cyc;
    repeat (PER - R2V - 1) tick();
  endtask

  function automatic logic [99:0] mkframe(input logic [6:0] s, input logic [6:0] m,
                                          input logic [5:0] h, input logic [9:0] d,
                                          input logic [7:0] y, input logic [16:0] b);
    logic [99:0] f;
    f = '0;
    f[4:1]   = s[3:0];  f[8:6]   = s[6:4];
    f[13:10] = m[3:0];  f[17:15] = m[6:4];
    f[23:20] = h[3:0];  f[26:25] = h[5:4];
    f[33:30] = d[3:0];  f[38:35] = d[7:4];  f[41:40] = d[9:8];
    f[53:50] = y[3:0];  f[58:55] = y[7:4];
    f[88:80] = b[8:0];  f[97:90] = b[16:9];
    return f;
  endfunction

  function automatic logic [1:0] fsym(input logic [99:0] f, input int i);
    if (i == 0 || (i % 10) == 9) return MK;
    return {1'b0, f[i]};
  endfunction

  task automatic send_frame(input logic [99:0] f, input ts_t t, input bit pps_on_pr);
    for (int i = 0; i < 100; i++) begin
      if (i == 99) exp_ts.push_back(t);
      send(fsym(f, i), pps_on_pr && (i == 0), 1'b0);
    end
  endtask

  task automatic send_span(input logic [99:0] f, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send(fsym(f, i), 1'b0, 1'b0);
  endtask

  initial begin
    logic [99:0] f42, f43;
    ts_t t42, t43;
    int t_first;
    f42 = mkframe(7'h42, 7'h59, 6'h17, 10'h293, 8'h16, 17'd64782);
    f43 = mkframe(7'h43, 7'h59, 6'h17, 10'h293, 8'h16, 17'd64783);
    t42 = '{s: 7'h42, m: 7'h59, h: 6'h17, d: 10'h293, y: 8'h16, b: 17'd0};
    t43 = '{s: 7'h43, m: 7'h59, h: 6'h17, d: 10'h293, y: 8'h16, b: 17'd0};
`ifdef IRIG_SBS_EN
    t42.b = 17'd64782;
    t43.b = 17'd64783;
`endif

    repeat (3) tick();
    chk("reset_outputs", 64'({pps, locked, ts_valid, frame_err, seconds, minutes,
                              hours, days, years, sbs_obs}), 64'd0);
    rst = 1'b1;
    tick();
    chk("reset_locked", 64'(locked), 64'd0);

    // Lock acquisition after garbage, P0, then a full frame.
    send(D0, 0, 0); send(MK, 0, 0); send(D1, 0, 0); send(D0, 0, 0);
    send(MK, 0, 0);
    chk("hunt_unlocked", 64'(locked), 64'd0);
    send_frame(f42, t42, 1'b0);
    chk("acq_locked", 64'(locked), 64'd1);
    chk("acq_years", 64'(years), 64'h16);

    // Back-to-back frame; its Pr edge and the following Pr edge both fire pps.
    t_first = last_ts;
    send_frame(f43, t43, 1'b1);
    chk("b2b_ts_spacing", 64'(last_ts - t_first), 64'(100 * PER));
    chk("b2b_seconds", 64'(seconds), 64'h43);
    send(MK, 1, 0);
    chk("b2b_pps_count", 64'(pps_cnt), 64'd2);

    // Marker violation: D1 where marker 29 belongs.
    send_span(f42, 1, 28);
    send(D1, 0, 1);
    chk("merr_locked", 64'(locked), 64'd0);
    send(D0, 0, 0);
    chk("merr_no_pps", 64'(pps_cnt), 64'd2);

    // Symbol timeout from the locked state.
    send(MK, 0, 0);
    send_frame(f42, t42, 1'b0);
    chk("to_locked", 64'(locked), 64'd1);
    exp_err.push_back(last_v + int'(TO));
    err_seen = 1'b0;
    while (!err_seen && cyc < last_v + int'(TO) + 50) tick();
    chk("to_fired", 64'(err_seen), 64'd1);
    chk("to_unlocked", 64'(locked), 64'd0);
    repeat (2 * TO) tick();
    send(D0, 0, 0);
    chk("to_no_pps", 64'(pps_cnt), 64'd2);
    chk("to_fields_held", 64'(seconds), 64'h42);

    // Asynchronous reset in the middle of symbol 45.
    send(MK, 0, 0);
    send_frame(f42, t42, 1'b0);
    send(MK, 1, 0);
    send_span(f42, 1, 44);
    sym_rise = 1'b1;
    tick();
    sym_rise = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_async_outputs", 64'({pps, locked, ts_valid, frame_err, seconds, minutes,
                                  hours, days, years, sbs_obs}), 64'd0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    send_span(f42, 46, 98);
    chk("rst_still_unlocked", 64'(locked), 64'd0);
    send(MK, 0, 0);
    send_frame(f43, t43, 1'b0);
    chk("rst_resync_locked", 64'(locked), 64'd1);
    chk("rst_resync_seconds", 64'(seconds), 64'h43);

    repeat (5) tick();
    chk("pps_total", 64'(pps_cnt), 64'd3);
    chk("queues_drained", 64'(exp_ts.size() + exp_err.size() + exp_pps.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
